// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   ctrl_state_t : sequencer FSM states (RUN, LOAD_STALL, REDIRECT)
//   REG_ZERO     : architectural x0, which never carries a real dependency
//   CNT_W        : width of the multi-cycle down-counter
package pipeline_ctrl_pkg;

  localparam int unsigned CNT_W = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    REDIRECT   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_load_use.sv
// load_use_detector: purely combinational load-use hazard detection.
// Ports:
//   rs1_Decode, rs2_Decode           in  5  source registers in Decode
//   uses_rs1_Decode, uses_rs2_Decode in  1  source actually read
//   valid_Decode                     in  1  Decode holds a real instruction
//   rd_Execute                       in  5  destination in Execute
//   mem_Read_Execute                 in  1  Execute instruction is a load
//   valid_Execute                    in  1  Execute holds a real instruction
//   lu                               out 1  load-use hazard present
module load_use_detector
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs1_Decode,
  input  logic [4:0] rs2_Decode,
  input  logic       uses_rs1_Decode,
  input  logic       uses_rs2_Decode,
  input  logic       valid_Decode,
  input  logic [4:0] rd_Execute,
  input  logic       mem_Read_Execute,
  input  logic       valid_Execute,
  output logic       lu
);

  logic [4:0] src_reg [2];
  logic [1:0] src_used;
  logic [1:0] src_hit;

  assign src_reg[0] = rs1_Decode;
  assign src_reg[1] = rs2_Decode;
  assign src_used   = {uses_rs2_Decode, uses_rs1_Decode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_used[gi] & (src_reg[gi] == rd_Execute);
  end

  // A load into x0 produces nothing to wait for.
  assign lu = valid_Decode & valid_Execute & mem_Read_Execute &
              (rd_Execute != REG_ZERO) & (|src_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: STALL/DUMP sequencer for the five-stage core.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN (adds stall_Cycles and
// flush_Events performance counters).
// Ports:
//   clock, reset_n                   in   clock, async active-low reset
//   rs1/rs2/uses_rs1/uses_rs2/valid_Decode  in  Decode-stage fields
//   rd/mem_Read/valid/branch_Taken_Execute  in  Execute-stage fields
//   mem_Busy                         in   data memory wait
//   STALL_PC, STALL_Fetch_Decode, STALL_Decode_Execute,
//   STALL_Execute_Memory             out  hold the register
//   DUMP_Fetch_Decode, DUMP_Decode_Execute  out  load a bubble
//   stall_Cycles, flush_Events       out  32-bit counters (macro only)
//   ctrl_State                       out  current FSM state
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned REDIRECT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rs1_Decode,
  input  logic [4:0]  rs2_Decode,
  input  logic        uses_rs1_Decode,
  input  logic        uses_rs2_Decode,
  input  logic        valid_Decode,
  input  logic [4:0]  rd_Execute,
  input  logic        mem_Read_Execute,
  input  logic        valid_Execute,
  input  logic        branch_Taken_Execute,
  input  logic        mem_Busy,
  output logic        STALL_PC,
  output logic        STALL_Fetch_Decode,
  output logic        STALL_Decode_Execute,
  output logic        STALL_Execute_Memory,
  output logic        DUMP_Fetch_Decode,
  output logic        DUMP_Decode_Execute,
`ifdef HAZARD_PERF_COUNTERS_EN
  output logic [31:0] stall_Cycles,
  output logic [31:0] flush_Events,
`endif
  output logic [1:0]  ctrl_State
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LOAD_USE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REDIR_RELOAD = CNT_W'(REDIRECT_CYCLES - 1);

  ctrl_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             lu;
  logic             br;

  load_use_detector u_load_use (
    .rs1_Decode       (rs1_Decode),
    .rs2_Decode       (rs2_Decode),
    .uses_rs1_Decode  (uses_rs1_Decode),
    .uses_rs2_Decode  (uses_rs2_Decode),
    .valid_Decode     (valid_Decode),
    .rd_Execute       (rd_Execute),
    .mem_Read_Execute (mem_Read_Execute),
    .valid_Execute    (valid_Execute),
    .lu               (lu)
  );

  assign br         = branch_Taken_Execute & valid_Execute;
  assign ctrl_State = state_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next           = state_reg;
    cnt_next             = cnt_reg;
    STALL_PC             = 1'b0;
    STALL_Fetch_Decode   = 1'b0;
    STALL_Decode_Execute = 1'b0;
    STALL_Execute_Memory = 1'b0;
    DUMP_Fetch_Decode    = 1'b0;
    DUMP_Decode_Execute  = 1'b0;

    if (!reset_n) begin
      // Flood the moderators with bubbles while reset is held.
      DUMP_Fetch_Decode   = 1'b1;
      DUMP_Decode_Execute = 1'b1;
    end else if (mem_Busy) begin
      // Whole pipeline freezes; state and counter hold by default.
      STALL_PC             = 1'b1;
      STALL_Fetch_Decode   = 1'b1;
      STALL_Decode_Execute = 1'b1;
      STALL_Execute_Memory = 1'b1;
    end else if (br) begin
      // Redirect wins over any load stall or redirect in progress.
      DUMP_Fetch_Decode   = 1'b1;
      DUMP_Decode_Execute = 1'b1;
      if (REDIRECT_CYCLES > 1) begin
        state_next = REDIRECT;
        cnt_next   = REDIR_RELOAD;
      end else begin
        state_next = RUN;
        cnt_next   = '0;
      end
    end else begin
      unique case (state_reg)
        RUN: begin
          if (lu) begin
            STALL_PC            = 1'b1;
            STALL_Fetch_Decode  = 1'b1;
            DUMP_Decode_Execute = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_next = LOAD_STALL;
              cnt_next   = LU_RELOAD;
            end
          end
        end
        LOAD_STALL: begin
          STALL_PC            = 1'b1;
          STALL_Fetch_Decode  = 1'b1;
          DUMP_Decode_Execute = 1'b1;
          cnt_next            = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) state_next = RUN;
        end
        REDIRECT: begin
          DUMP_Fetch_Decode   = 1'b1;
          DUMP_Decode_Execute = 1'b1;
          cnt_next            = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) state_next = RUN;
        end
        default: begin
          state_next = RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_events_reg;

  // Both counters wrap naturally on overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (STALL_PC) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (br && !mem_Busy) flush_events_reg <= flush_events_reg + 32'd1;
    end
  end

  assign stall_Cycles = stall_cycles_reg;
  assign flush_Events = flush_events_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller. Two instances share the
// same stimulus: dut_a (LOAD_USE_CYCLES=1, REDIRECT_CYCLES=2) and
// dut_b (LOAD_USE_CYCLES=3, REDIRECT_CYCLES=1). Each step drives inputs just
// after a rising edge and queues the hand-computed outputs of both; the
// monitor pops and compares on the following falling edge.
module tb_pipeline_hazard_controller;

  // Packed control word: {STALL_PC, STALL_FD, STALL_DE, STALL_EM, DUMP_FD, DUMP_DE}
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110001;
  localparam logic [5:0] C_BUSY  = 6'b111100;
  localparam logic [5:0] C_FLUSH = 6'b000011;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs1_Decode = 5'd1, rs2_Decode = 5'd2, rd_Execute = 5'd5;
  logic       uses_rs1_Decode = 1'b1, uses_rs2_Decode = 1'b1, valid_Decode = 1'b1;
  logic       mem_Read_Execute = 1'b0, valid_Execute = 1'b1;
  logic       branch_Taken_Execute = 1'b0, mem_Busy = 1'b0;

  logic       a_spc, a_sfd, a_sde, a_sem, a_dfd, a_dde;
  logic       b_spc, b_sfd, b_sde, b_sem, b_dfd, b_dde;
  logic [1:0] a_state, b_state;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] a_stalls, a_flushes, b_stalls, b_flushes;
`endif

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.LOAD_USE_CYCLES(1), .REDIRECT_CYCLES(2)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .rs1_Decode(rs1_Decode), .rs2_Decode(rs2_Decode),
    .uses_rs1_Decode(uses_rs1_Decode), .uses_rs2_Decode(uses_rs2_Decode),
    .valid_Decode(valid_Decode), .rd_Execute(rd_Execute),
    .mem_Read_Execute(mem_Read_Execute), .valid_Execute(valid_Execute),
    .branch_Taken_Execute(branch_Taken_Execute), .mem_Busy(mem_Busy),
    .STALL_PC(a_spc), .STALL_Fetch_Decode(a_sfd),
    .STALL_Decode_Execute(a_sde), .STALL_Execute_Memory(a_sem),
    .DUMP_Fetch_Decode(a_dfd), .DUMP_Decode_Execute(a_dde),
`ifdef HAZARD_PERF_COUNTERS_EN
    .stall_Cycles(a_stalls), .flush_Events(a_flushes),
`endif
    .ctrl_State(a_state)
  );

  pipeline_hazard_controller #(.LOAD_USE_CYCLES(3), .REDIRECT_CYCLES(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .rs1_Decode(rs1_Decode), .rs2_Decode(rs2_Decode),
    .uses_rs1_Decode(uses_rs1_Decode), .uses_rs2_Decode(uses_rs2_Decode),
    .valid_Decode(valid_Decode), .rd_Execute(rd_Execute),
    .mem_Read_Execute(mem_Read_Execute), .valid_Execute(valid_Execute),
    .branch_Taken_Execute(branch_Taken_Execute), .mem_Busy(mem_Busy),
    .STALL_PC(b_spc), .STALL_Fetch_Decode(b_sfd),
    .STALL_Decode_Execute(b_sde), .STALL_Execute_Memory(b_sem),
    .DUMP_Fetch_Decode(b_dfd), .DUMP_Decode_Execute(b_dde),
`ifdef HAZARD_PERF_COUNTERS_EN
    .stall_Cycles(b_stalls), .flush_Events(b_flushes),
`endif
    .ctrl_State(b_state)
  );

  typedef struct {
    string       name;
    logic [7:0]  ea;
    logic [7:0]  eb;
    bit          cnt_chk;
    logic [31:0] sa, fa, sb, fb;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  // hz: 0 no load in Execute, 1 load x5 / rs1=x5, 2 load x0 / rs1=x0,
  //     3 load x5 / rs1=x5 but rs1 unused, 4 load x5 / rs2=x5
  task automatic step(input string name, input int hz, input bit br,
                      input bit mb, input bit rn,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input bit cc = 1'b0,
                      input logic [31:0] sa = 0, input logic [31:0] fa = 0,
                      input logic [31:0] sb = 0, input logic [31:0] fb = 0);
    exp_t e;
    @(posedge clock);
    #1;
    rs1_Decode = 5'd1; rs2_Decode = 5'd2; rd_Execute = 5'd5;
    uses_rs1_Decode = 1'b1; uses_rs2_Decode = 1'b1;
    valid_Decode = 1'b1; valid_Execute = 1'b1; mem_Read_Execute = 1'b1;
    case (hz)
      0: mem_Read_Execute = 1'b0;
      1: rs1_Decode = 5'd5;
      2: begin rs1_Decode = 5'd0; rd_Execute = 5'd0; end
      3: begin rs1_Decode = 5'd5; uses_rs1_Decode = 1'b0; end
      4: rs2_Decode = 5'd5;
      default: mem_Read_Execute = 1'b0;
    endcase
    branch_Taken_Execute = br;
    mem_Busy = mb;
    reset_n = rn;
    e.name = name; e.ea = ea; e.eb = eb; e.cnt_chk = cc;
    e.sa = sa; e.fa = fa; e.sb = sb; e.fb = fb;
    sb_q.push_back(e);
  endtask

  exp_t       cur;
  logic [7:0] got_a, got_b;

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      cur   = sb_q.pop_front();
      got_a = {a_spc, a_sfd, a_sde, a_sem, a_dfd, a_dde, a_state};
      got_b = {b_spc, b_sfd, b_sde, b_sem, b_dfd, b_dde, b_state};
      checks++;
      if (got_a === cur.ea) passed++;
      else $display("FAIL %s dut_a ctl/state got %b expected %b", cur.name, got_a, cur.ea);
      checks++;
      if (got_b === cur.eb) passed++;
      else $display("FAIL %s dut_b ctl/state got %b expected %b", cur.name, got_b, cur.eb);
`ifdef HAZARD_PERF_COUNTERS_EN
      if (cur.cnt_chk) begin
        checks++;
        if ({a_stalls, a_flushes, b_stalls, b_flushes} === {cur.sa, cur.fa, cur.sb, cur.fb})
          passed++;
        else
          $display("FAIL %s counters got a=%0d/%0d b=%0d/%0d expected a=%0d/%0d b=%0d/%0d",
                   cur.name, a_stalls, a_flushes, b_stalls, b_flushes,
                   cur.sa, cur.fa, cur.sb, cur.fb);
      end
`endif
      $display("step %-14s a=%b b=%b", cur.name, got_a, got_b);
    end
  end

  initial begin
    step("reset",        0, 0, 0, 0, {C_FLUSH, 2'd0}, {C_FLUSH, 2'd0});
    step("idle",         0, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0});
    step("lu_rs1",       1, 0, 0, 1, {C_LU, 2'd0},    {C_LU, 2'd0});
    step("lu_tail1",     0, 0, 0, 1, {C_IDLE, 2'd0},  {C_LU, 2'd1});
    step("lu_tail2",     0, 0, 0, 1, {C_IDLE, 2'd0},  {C_LU, 2'd1});
    step("lu_done",      0, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0},
         1'b1, 32'd1, 32'd0, 32'd3, 32'd0);
    step("rd_x0",        2, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0});
    step("rs1_unused",   3, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0});
    step("lu_rs2",       4, 0, 0, 1, {C_LU, 2'd0},    {C_LU, 2'd0});
    step("busy1",        0, 0, 1, 1, {C_BUSY, 2'd0},  {C_BUSY, 2'd1});
    step("busy2",        0, 0, 1, 1, {C_BUSY, 2'd0},  {C_BUSY, 2'd1});
    step("lu_resume1",   0, 0, 0, 1, {C_IDLE, 2'd0},  {C_LU, 2'd1});
    step("lu_resume2",   0, 0, 0, 1, {C_IDLE, 2'd0},  {C_LU, 2'd1});
    step("lu_end",       0, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0});
    step("br",           0, 1, 0, 1, {C_FLUSH, 2'd0}, {C_FLUSH, 2'd0});
    step("redir2",       0, 0, 0, 1, {C_FLUSH, 2'd2}, {C_IDLE, 2'd0});
    step("redir_end",    0, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0});
    step("br_busy",      0, 1, 1, 1, {C_BUSY, 2'd0},  {C_BUSY, 2'd0});
    step("br_after",     0, 1, 0, 1, {C_FLUSH, 2'd0}, {C_FLUSH, 2'd0});
    step("br_in_redir",  0, 1, 0, 1, {C_FLUSH, 2'd2}, {C_FLUSH, 2'd0});
    step("redir_again",  0, 0, 0, 1, {C_FLUSH, 2'd2}, {C_IDLE, 2'd0});
    step("idle2",        0, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0});
    step("lu_pre_br",    1, 0, 0, 1, {C_LU, 2'd0},    {C_LU, 2'd0});
    step("br_over_lu",   0, 1, 0, 1, {C_FLUSH, 2'd0}, {C_FLUSH, 2'd1});
    step("redir3",       0, 0, 0, 1, {C_FLUSH, 2'd2}, {C_IDLE, 2'd0});
    step("idle3",        0, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0},
         1'b1, 32'd6, 32'd4, 32'd10, 32'd4);
    step("lu_pre_rst",   1, 0, 0, 1, {C_LU, 2'd0},    {C_LU, 2'd0});
    step("rst_in_stall", 0, 0, 0, 0, {C_FLUSH, 2'd0}, {C_FLUSH, 2'd0},
         1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
    step("post_rst",     0, 0, 0, 1, {C_IDLE, 2'd0},  {C_IDLE, 2'd0});

    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain pending got %0d required 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central pipeline sequencer for the five-stage RISC-V core. It generates the STALL and DUMP controls for every inter-stage moderator register (Fetch/Decode, Decode/Execute, Execute/Memory) and for the PC register. It resolves load-use hazards, taken-branch redirects and data-memory wait states. Hazard decisions are combinational from the current stage contents, and a small FSM with a down-counter sequences multi-cycle stalls and redirects.

## Interface
- LOAD_USE_CYCLES, 1: bubbles inserted per load-use hazard (1..15).
- REDIRECT_CYCLES, 1: cycles the front-end DUMPs are held after a taken branch (1..15).

- clock  input  1  rising-edge clock.
- reset_n  input  1  reset; asynchronous assert, active-low.
- rs1_Decode, rs2_Decode  input  5 each  source registers of the instruction in Decode.
- uses_rs1_Decode, uses_rs2_Decode  input  1 each  source actually read.
- valid_Decode  input  1  Decode holds a real instruction.
- rd_Execute  input  5  destination register in Execute.
- mem_Read_Execute  input  1  Execute instruction is a load.
- valid_Execute  input  1  Execute holds a real instruction.
- branch_Taken_Execute  input  1  resolved taken branch/jump in Execute.
- mem_Busy  input  1  data memory not ready; pipeline must freeze.
- STALL_PC, STALL_Fetch_Decode, STALL_Decode_Execute, STALL_Execute_Memory  output  1 each  hold the register.
- DUMP_Fetch_Decode, DUMP_Decode_Execute  output  1 each  load a bubble.
- ctrl_State  output  2  current FSM state (debug).

## Operation
- States: RUN=0, LOAD_STALL=1, REDIRECT=2. Down-counter cnt is 4 bits wide.
- Let lu = valid_Decode & valid_Execute & mem_Read_Execute & rd_Execute≠0 & ((uses_rs1_Decode & rs1_Decode==rd_Execute) | (uses_rs2_Decode & rs2_Decode==rd_Execute)).
- Let br = branch_Taken_Execute & valid_Execute.
- Priority in every state: mem_Busy > br > lu/counter.
- mem_Busy=1:
  - All four STALL outputs are 1 and both DUMP outputs are 0.
  - State and cnt are frozen.
- br=1:
  - DUMP_Fetch_Decode=1 and DUMP_Decode_Execute=1. All STALLs are 0.
  - If REDIRECT_CYCLES>1: next state REDIRECT, cnt←REDIRECT_CYCLES−1.
  - Otherwise: next state RUN.
  - br overrides any in-progress load stall.
- RUN with lu=1:
  - STALL_PC=1, STALL_Fetch_Decode=1, DUMP_Decode_Execute=1. Other outputs are 0.
  - If LOAD_USE_CYCLES>1: next state LOAD_STALL, cnt←LOAD_USE_CYCLES−1.
- LOAD_STALL:
  - Outputs are the same as RUN with lu=1, regardless of lu.
  - cnt decrements each cycle. When cnt==1, next state is RUN.
- REDIRECT:
  - Both DUMP outputs are 1.
  - cnt decrements each cycle. When cnt==1, next state is RUN.
- RUN with nothing active: all outputs are 0.
- rd_Execute==0 never causes a stall.

## Timing
- Control outputs are combinational from state and inputs. They are valid in the same cycle as the hazard, before the next clock edge.
- Reset (reset_n=0, asynchronous): state←RUN, cnt←0, ctrl_State=0.
  - All STALL outputs are forced to 0 and both DUMP outputs are forced to 1, so the moderators fill with bubbles.
  - Reset asserted mid-stall or mid-redirect aborts that sequence immediately.
- Load-use penalty is exactly LOAD_USE_CYCLES cycles, plus any mem_Busy cycles.
- Redirect penalty is exactly REDIRECT_CYCLES DUMP cycles, plus any mem_Busy cycles.
- br while in REDIRECT restarts cnt at REDIRECT_CYCLES−1.

## Configuration
- HAZARD_PERF_COUNTERS_EN defined:
  - Adds output ports stall_Cycles[31:0] and flush_Events[31:0], both reset to 0 and wrapping on overflow.
  - stall_Cycles increments on every cycle with STALL_PC=1 while reset_n=1.
  - flush_Events increments once per accepted br.
- Not defined: these ports and their registers are absent. Control behaviour is identical either way.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (RUN, LOAD_STALL, REDIRECT);
  - the constant REG_ZERO=5'd0;
  - the counter width CNT_W=4.
- One sub-module is natural: load_use_detector, which is purely combinational and produces lu from the Decode/Execute fields.

## Test plan
- Load x5 in Execute, Decode `add` reads rs1=x5, LOAD_USE_CYCLES=1 → one cycle of STALL_PC=STALL_Fetch_Decode=DUMP_Decode_Execute=1, then all 0; state stays 0.
- Same hazard with rd_Execute=0, or with uses_rs1_Decode=0 → no stall.
- br=1, REDIRECT_CYCLES=2 → both DUMPs high for 2 cycles, ctrl_State=2 in cycle 2, then RUN.
- LOAD_USE_CYCLES=3, mem_Busy high for 2 cycles during the stall's 2nd cycle → all STALLs high for those 2 cycles, total load-stall cycles still 3; mem_Busy with br asserted → stall wins, DUMPs=0.
- reset_n dropped in LOAD_STALL → same-cycle DUMPs=1, STALLs=0, state 0; with HAZARD_PERF_COUNTERS_EN, counters read 0 after reset and stall_Cycles=3 after one LOAD_USE_CYCLES=3 hazard.
